// File: rtl/fir_pkg.sv
// Shared types and sizing for the 8-tap FIR sequencer.
package fir_pkg;

    localparam int FIR_TAPS   = 8;
    localparam int FIR_ADDR_W = 3;
    localparam int FIR_DATA_W = 8;

    // Full-precision sum of TAPS products: 2*DATA_WIDTH plus log2(TAPS) guard bits.
    function automatic int fir_acc_width(input int data_width);
        return 2 * data_width + 3;
    endfunction

    localparam int FIR_ACC_W = fir_acc_width(FIR_DATA_W);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MAC   = 2'd1,
        DRAIN = 2'd2,
        OUT   = 2'd3
    } fir_state_t;

endpackage

// File: rtl/fir_ctrl_if.sv
// Sample input, delay-line RAM, coefficient file and result port of the FIR sequencer.
interface fir_ctrl_if import fir_pkg::*; #(
    parameter int DATA_WIDTH = FIR_DATA_W,
    parameter int ACC_WIDTH  = fir_acc_width(DATA_WIDTH)
);
    logic                          in_valid;
    logic                          in_ready;
    logic signed [DATA_WIDTH-1:0]  in_data;
    logic                          ram_en;
    logic                          ram_we;
    logic [FIR_ADDR_W-1:0]         ram_addr;
    logic signed [DATA_WIDTH-1:0]  ram_di;
    logic signed [DATA_WIDTH-1:0]  ram_dio;
    logic [FIR_ADDR_W-1:0]         coef_addr;
    logic signed [DATA_WIDTH-1:0]  coef_data;
    logic                          out_valid;
    logic                          out_ready;
    logic signed [ACC_WIDTH-1:0]   out_data;

    // master is the sequencer; slave is the surrounding source, RAM, coefficients and sink.
    modport master (
        input  in_valid, in_data, ram_dio, coef_data, out_ready,
        output in_ready, ram_en, ram_we, ram_addr, ram_di, coef_addr, out_valid, out_data
    );

    modport slave (
        output in_valid, in_data, ram_dio, coef_data, out_ready,
        input  in_ready, ram_en, ram_we, ram_addr, ram_di, coef_addr, out_valid, out_data
    );

endinterface

// File: rtl/fir_mac.sv
// Signed multiply-accumulate; clear has priority over enable.
module fir_mac #(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 19
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         clear,
    input  logic                         en,
    input  logic signed [DATA_WIDTH-1:0] a,
    input  logic signed [DATA_WIDTH-1:0] b,
    output logic signed [ACC_WIDTH-1:0]  acc
);
    logic signed [2*DATA_WIDTH-1:0] prod;
    logic signed [ACC_WIDTH-1:0]    prod_ext;

    assign prod     = a * b;
    assign prod_ext = {{(ACC_WIDTH-2*DATA_WIDTH){prod[2*DATA_WIDTH-1]}}, prod};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            acc <= '0;
        end else if (clear) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc + prod_ext;
        end
    end

endmodule

// File: rtl/fir_ctrl.sv
// FIR sequencer: accept a sample, shift it into the delay line, walk all taps, present the sum.
module fir_ctrl import fir_pkg::*; #(
    parameter int DATA_WIDTH = FIR_DATA_W,
    parameter int TAPS       = FIR_TAPS,
    parameter int ACC_WIDTH  = fir_acc_width(DATA_WIDTH)
) (
    input  logic      clock,
    input  logic      reset,
    fir_ctrl_if.master bus
);
    localparam logic [FIR_ADDR_W-1:0] LAST_TAP = FIR_ADDR_W'(TAPS - 1);

    fir_state_t                    state_reg, state_next;
    logic [FIR_ADDR_W-1:0]         k_reg, k_next;
    logic                          pend_reg;
    logic signed [DATA_WIDTH-1:0]  coef_q_reg;
    logic signed [ACC_WIDTH-1:0]   acc;

    logic                          acc_clear;
    logic                          in_ready;
    logic                          ram_en;
    logic                          ram_we;
    logic [FIR_ADDR_W-1:0]         ram_addr;
    logic signed [DATA_WIDTH-1:0]  ram_di;
    logic [FIR_ADDR_W-1:0]         coef_addr;
    logic                          out_valid;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg  <= IDLE;
            k_reg      <= '0;
            pend_reg   <= 1'b0;
            coef_q_reg <= '0;
        end else begin
            state_reg <= state_next;
            k_reg     <= k_next;
            // RAM read data lags the address by one cycle, so the coefficient is delayed to match.
            pend_reg  <= (state_reg == MAC);
            if (state_reg == MAC) begin
                coef_q_reg <= bus.coef_data;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        k_next     = k_reg;
        acc_clear  = 1'b0;
        in_ready   = 1'b0;
        ram_en     = 1'b0;
        ram_we     = 1'b0;
        ram_addr   = '0;
        ram_di     = '0;
        coef_addr  = '0;
        out_valid  = 1'b0;
        unique case (state_reg)
            IDLE: begin
                in_ready = 1'b1;
                if (bus.in_valid) begin
                    ram_en     = 1'b1;
                    ram_we     = 1'b1;
                    ram_di     = bus.in_data;
                    acc_clear  = 1'b1;
                    k_next     = '0;
                    state_next = MAC;
                end
            end
            MAC: begin
                ram_en    = 1'b1;
                ram_addr  = k_reg;
                coef_addr = k_reg;
                if (k_reg == LAST_TAP) begin
                    state_next = DRAIN;
                end else begin
                    k_next = k_reg + 1'b1;
                end
            end
            DRAIN: begin
                state_next = OUT;
            end
            OUT: begin
                out_valid = 1'b1;
                if (bus.out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    fir_mac #(
        .DATA_WIDTH (DATA_WIDTH),
        .ACC_WIDTH  (ACC_WIDTH)
    ) u_mac (
        .clock (clock),
        .reset (reset),
        .clear (acc_clear),
        .en    (pend_reg),
        .a     (bus.ram_dio),
        .b     (coef_q_reg),
        .acc   (acc)
    );

    assign bus.in_ready  = in_ready;
    assign bus.ram_en    = ram_en;
    assign bus.ram_we    = ram_we;
    assign bus.ram_addr  = ram_addr;
    assign bus.ram_di    = ram_di;
    assign bus.coef_addr = coef_addr;
    assign bus.out_valid = out_valid;
    assign bus.out_data  = acc;

endmodule
